fastpath_sum: RTL
=================

# fastpath_sum

Parametrised multi-operand adder with a zero-operand fast path, a two-stage valid/ready pipeline, and selectable wrap or saturate arithmetic. It sums NUM_IN tainted operands into one WIDTH-bit result and flags results produced by the all-zero fast path. It sits between source ports and a sink register in the information-flow test suite. Unlike the single-cycle fixed-width form, the fast-path flag is registered alongside its own sum, so the flag and the data always come from the same operand set.

## Interface
- WIDTH, 2: bit width of each operand and of the result.
- NUM_IN, 2: number of operands (≥2).
- SATURATE, 0: 0 = result wraps modulo 2^WIDTH; 1 = result clamps to 2^WIDTH-1.
- RESET_OUT, 2: reset value of `out` (must fit in WIDTH bits).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts an operand set this cycle.
- in_data  in  NUM_IN*WIDTH  packed operands; operand i is bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result this cycle.
- out  out  WIDTH  result (registered).
- out_fast  out  1  result came from the fast path (registered).

## Operation
- Accept: an operand set is accepted when in_valid && in_ready at a rising edge.
- Stage 1 (registers s1_valid, s1_sum, s1_fast), loaded on accept:
  - fast = (OR of all operand bits) == 0.
  - Full sum is computed at width WIDTH+clog2(NUM_IN), so there is no intermediate overflow.
  - SATURATE=0: s1_sum = full sum[WIDTH-1:0].
  - SATURATE=1: s1_sum = min(full sum, 2^WIDTH-1).
  - When fast=1, s1_sum is forced to 0 and the adder result is ignored.
- Stage 2 (the output registers out_valid, out, out_fast): load s1_sum and s1_fast when stage 1 is valid and stage 2 advances.
- Advance rules:
  - adv2 = !out_valid || out_ready.
  - in_ready = !rst && (!s1_valid || adv2).
  - s1_valid next = accept ? 1 : (adv2 ? 0 : s1_valid).
  - out_valid next = adv2 ? s1_valid : out_valid.
- Hold: while out_valid && !out_ready, out and out_fast are held stable and stage 1 holds its contents.
- When out_valid=0, `out` keeps its last value and carries no meaning.
- Reset: s1_valid=0, out_valid=0, out=RESET_OUT, out_fast=0. Stage-1 data registers reset to 0 so no tainted residue remains.
- Ordering: results leave in acceptance order; no set is lost or duplicated.

## Timing
- Latency: an operand set accepted at edge E0 appears with out_valid=1 after edge E1, provided stage 2 was free at E1.
- Throughput: 1 set per cycle while out_ready=1.
- Capacity: 2 sets in flight (stage 1 + stage 2). in_ready falls the cycle both stages are full and out_ready=0.
- Simultaneous events: out handshake, stage-1→stage-2 move, and a new accept can all occur on the same edge when out_ready=1.
- in_ready is combinational from out_valid, s1_valid, out_ready and rst. There is no combinational path from in_data to any output.
- Reset mid-operation: rst high at edge E flushes both stages. After E, out_valid=0 and in_ready=0 while rst is held. In-flight sets are discarded, and any in_valid during rst is ignored.
- Wrap-around: with SATURATE=0, overflow silently drops carry bits and no flag is raised.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 → out=2, out_valid=0, out_fast=0, in_ready=0. After release, in_ready=1 and nothing is emitted.
- Basic sum (defaults): accept {in0=1, in1=2} at E0, out_ready=1 → after E1 out_valid=1, out=3, out_fast=0. Valid for exactly one cycle.
- Fast path: accept {0,0} → after 2 edges out=0, out_fast=1. Then accept {0,1} → out=1, out_fast=0, so the flag tracks its own set.
- Overflow: accept {3,3} → SATURATE=0 gives out=2; SATURATE=1 gives out=3. With NUM_IN=4, SATURATE=0, operands {3,3,3,3} → out=0 and out_fast=0.
- Backpressure: stream sets with sums 1,2,3,4 while out_ready=0 for 3 cycles → in_ready drops after 2 accepts. After out_ready rises, outputs 1,2,3,4 appear in order with no gaps or repeats, and out is stable while stalled.
- Mid-stream reset: both stages full, pulse rst for 1 cycle → out_valid=0 and out=2 next cycle. The flushed sets never appear, and the next accepted set emerges after 2 edges.

Source files
------------

// File: rtl/fastpath_sum.sv
// fastpath_sum: multi-operand adder with a two-stage valid/ready pipeline.
// Stage 1 holds the freshly summed operand set. Stage 2 is the output register.
// An all-zero operand set takes the fast path: its sum is forced to zero and
// out_fast is set. The flag travels with its own sum through both stages.
// SATURATE selects wrap (0) or clamp to 2^WIDTH-1 (1) arithmetic.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, flushes both stages
//   in_valid   operand set present on in_data
//   in_ready   block accepts an operand set this cycle
//   in_data    NUM_IN packed operands, operand i at [i*WIDTH +: WIDTH]
//   out_valid  result present
//   out_ready  sink accepts the result this cycle
//   out        registered result
//   out_fast   registered flag: result came from the all-zero fast path
module fastpath_sum #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned NUM_IN    = 2,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_fast
);

    // Wide enough that summing NUM_IN full-scale operands cannot overflow.
    localparam int unsigned      SUM_W   = WIDTH + $clog2(NUM_IN);
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({WIDTH{1'b1}});

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_sum_q,   s1_sum_d;
    logic             s1_fast_q,  s1_fast_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q,      out_d;
    logic             out_fast_q, out_fast_d;

    logic [SUM_W-1:0] full_sum;
    logic [WIDTH-1:0] sum_res;
    logic             op_fast;
    logic             adv2;
    logic             accept;

    always_comb begin
        full_sum = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            full_sum = full_sum + SUM_W'(in_data[i*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        op_fast = ~|in_data;
        if (SATURATE && (full_sum > MAX_SUM)) begin
            sum_res = MAX_SUM[WIDTH-1:0];
        end else begin
            sum_res = full_sum[WIDTH-1:0];
        end
    end

    always_comb begin
        adv2     = !out_valid_q || out_ready;
        in_ready = !rst && (!s1_valid_q || adv2);
        accept   = in_valid && in_ready;

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_fast_d   = s1_fast_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_fast_d  = out_fast_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_fast_d  = op_fast;
            s1_sum_d   = op_fast ? '0 : sum_res;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end

        // Output data only moves when a real stage-1 entry is promoted;
        // otherwise out keeps its last value.
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d      = s1_sum_q;
                out_fast_d = s1_fast_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_fast_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= WIDTH'(RESET_OUT);
            out_fast_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_fast_q   <= s1_fast_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_fast_q  <= out_fast_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_fast  = out_fast_q;

endmodule
